// File: rtl/fu_cdb_arb.sv
// Writeback arbiter: buffers FU results in 2-entry lane FIFOs and broadcasts one
// per cycle on a registered CDB, with round-robin grant and branch squash/mask clear.
module fu_cdb_arb #(
  parameter int NUM_FU     = 4,
  parameter int LANE_DEPTH = 2,
  parameter int PRF_IDX_W  = 6,
  parameter int ROB_IDX_W  = 5,
  parameter int BR_MASK_W  = 4
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [NUM_FU-1:0]                 fu_done_i,
  input  logic [64*NUM_FU-1:0]              fu_result_i,
  input  logic [PRF_IDX_W*NUM_FU-1:0]       fu_dest_tag_i,
  input  logic [(ROB_IDX_W+1)*NUM_FU-1:0]   fu_rob_idx_i,
  input  logic [BR_MASK_W*NUM_FU-1:0]       fu_br_mask_i,
  input  logic                              rob_br_recovery_i,
  input  logic                              rob_br_pred_correct_i,
  input  logic [BR_MASK_W-1:0]              rob_br_tag_fix_i,
  output logic [NUM_FU-1:0]                 fu_stall_o,
  output logic                              cdb_valid_o,
  output logic [63:0]                       cdb_result_o,
  output logic [PRF_IDX_W-1:0]              cdb_tag_o,
  output logic [ROB_IDX_W:0]                cdb_rob_idx_o,
  output logic [BR_MASK_W-1:0]              cdb_br_mask_o
);

  localparam int PTR_W = $clog2(NUM_FU);

  typedef struct packed {
    logic [63:0]           result;
    logic [PRF_IDX_W-1:0]  tag;
    logic [ROB_IDX_W:0]    rob_idx;
    logic [BR_MASK_W-1:0]  br_mask;
  } entry_t;

  entry_t [NUM_FU-1:0][LANE_DEPTH-1:0] slot_q, slot_d;
  logic   [NUM_FU-1:0][LANE_DEPTH-1:0] vld_q, vld_d;
  logic   [PTR_W-1:0]                  rr_q, rr_d;
  logic                                cdb_valid_q, cdb_valid_d;
  entry_t                              cdb_q, cdb_d;

  entry_t               in_e, e0, e1;
  logic [BR_MASK_W-1:0] clr;
  logic                 found, pop, push, k0, k1;
  logic [PTR_W-1:0]     gnt, idx;

  always_comb begin
    slot_d      = slot_q;
    vld_d       = vld_q;
    rr_d        = rr_q;
    cdb_valid_d = 1'b0;
    cdb_d       = cdb_q;
    clr         = (rob_br_pred_correct_i && !rob_br_recovery_i) ? rob_br_tag_fix_i : '0;
    found       = 1'b0;
    gnt         = '0;
    idx         = '0;
    in_e        = '0;
    e0          = '0;
    e1          = '0;
    pop         = 1'b0;
    push        = 1'b0;
    k0          = 1'b0;
    k1          = 1'b0;

    if (rob_br_recovery_i) begin
      // Squash dependent entries and compact survivors; no grant, no capture.
      for (int i = 0; i < NUM_FU; i++) begin
        k0 = |(slot_q[i][0].br_mask & rob_br_tag_fix_i);
        k1 = |(slot_q[i][1].br_mask & rob_br_tag_fix_i);
        if (vld_q[i][0] && !k0) begin
          vld_d[i][1] = vld_q[i][1] && !k1;
        end else if (vld_q[i][1] && !k1) begin
          slot_d[i][0] = slot_q[i][1];
          vld_d[i]     = 2'b01;
        end else begin
          vld_d[i] = 2'b00;
        end
      end
    end else begin
      for (int k = 0; k < NUM_FU; k++) begin
        idx = PTR_W'((int'(rr_q) + k) % NUM_FU);
        if (!found && vld_q[idx][0]) begin
          found = 1'b1;
          gnt   = idx;
        end
      end

      for (int i = 0; i < NUM_FU; i++) begin
        pop  = found && (gnt == PTR_W'(i));
        push = fu_done_i[i] && !vld_q[i][1];

        in_e.result  = fu_result_i[64*i +: 64];
        in_e.tag     = fu_dest_tag_i[PRF_IDX_W*i +: PRF_IDX_W];
        in_e.rob_idx = fu_rob_idx_i[(ROB_IDX_W+1)*i +: (ROB_IDX_W+1)];
        in_e.br_mask = fu_br_mask_i[BR_MASK_W*i +: BR_MASK_W] & ~clr;

        e0         = slot_q[i][0];
        e0.br_mask = e0.br_mask & ~clr;
        e1         = slot_q[i][1];
        e1.br_mask = e1.br_mask & ~clr;

        if (pop) begin
          slot_d[i][0] = e1;
          vld_d[i]     = {1'b0, vld_q[i][1]};
        end else begin
          slot_d[i][0] = e0;
          slot_d[i][1] = e1;
        end

        if (push) begin
          if (!vld_d[i][0]) begin
            slot_d[i][0] = in_e;
            vld_d[i][0]  = 1'b1;
          end else begin
            slot_d[i][1] = in_e;
            vld_d[i][1]  = 1'b1;
          end
        end
      end

      if (found) begin
        cdb_valid_d   = 1'b1;
        cdb_d         = slot_q[gnt][0];
        cdb_d.br_mask = cdb_d.br_mask & ~clr;
        rr_d          = PTR_W'((int'(gnt) + 1) % NUM_FU);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      slot_q      <= '0;
      vld_q       <= '0;
      rr_q        <= '0;
      cdb_valid_q <= 1'b0;
      cdb_q       <= '0;
    end else begin
      slot_q      <= slot_d;
      vld_q       <= vld_d;
      rr_q        <= rr_d;
      cdb_valid_q <= cdb_valid_d;
      cdb_q       <= cdb_d;
    end
  end

  // Full lane stalls even when it is being drained this cycle.
  always_comb begin
    for (int i = 0; i < NUM_FU; i++) fu_stall_o[i] = vld_q[i][1];
  end

  assign cdb_valid_o   = cdb_valid_q;
  assign cdb_result_o  = cdb_q.result;
  assign cdb_tag_o     = cdb_q.tag;
  assign cdb_rob_idx_o = cdb_q.rob_idx;
  assign cdb_br_mask_o = cdb_q.br_mask;

endmodule

// File: tb/tb_fu_cdb_arb.sv
// Scoreboard bench for fu_cdb_arb: directed stimulus pushes expected broadcasts,
// a negedge monitor pops and compares every CDB valid.
module tb_fu_cdb_arb;
  localparam int N  = 4;
  localparam int PW = 6;
  localparam int RW = 5;
  localparam int BW = 4;

  logic                  clk = 1'b0;
  logic                  rst = 1'b1;
  logic [N-1:0]          fu_done_i = '0;
  logic [64*N-1:0]       fu_result_i = '0;
  logic [PW*N-1:0]       fu_dest_tag_i = '0;
  logic [(RW+1)*N-1:0]   fu_rob_idx_i = '0;
  logic [BW*N-1:0]       fu_br_mask_i = '0;
  logic                  rob_br_recovery_i = 1'b0;
  logic                  rob_br_pred_correct_i = 1'b0;
  logic [BW-1:0]         rob_br_tag_fix_i = '0;
  logic [N-1:0]          fu_stall_o;
  logic                  cdb_valid_o;
  logic [63:0]           cdb_result_o;
  logic [PW-1:0]         cdb_tag_o;
  logic [RW:0]           cdb_rob_idx_o;
  logic [BW-1:0]         cdb_br_mask_o;

  fu_cdb_arb #(.NUM_FU(N), .LANE_DEPTH(2), .PRF_IDX_W(PW), .ROB_IDX_W(RW), .BR_MASK_W(BW)) dut (
    .clk(clk), .rst(rst),
    .fu_done_i(fu_done_i), .fu_result_i(fu_result_i), .fu_dest_tag_i(fu_dest_tag_i),
    .fu_rob_idx_i(fu_rob_idx_i), .fu_br_mask_i(fu_br_mask_i),
    .rob_br_recovery_i(rob_br_recovery_i), .rob_br_pred_correct_i(rob_br_pred_correct_i),
    .rob_br_tag_fix_i(rob_br_tag_fix_i), .fu_stall_o(fu_stall_o),
    .cdb_valid_o(cdb_valid_o), .cdb_result_o(cdb_result_o), .cdb_tag_o(cdb_tag_o),
    .cdb_rob_idx_o(cdb_rob_idx_o), .cdb_br_mask_o(cdb_br_mask_o)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [63:0]   res;
    logic [PW-1:0] tag;
    logic [RW:0]   rob;
    logic [BW-1:0] mask;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic expect_cdb(input logic [63:0] res, input int tag, input int rob, input logic [BW-1:0] mask);
    exp_t e;
    e.res  = res;
    e.tag  = PW'(tag);
    e.rob  = (RW+1)'(rob);
    e.mask = mask;
    sb.push_back(e);
  endtask

  task automatic drive(input int l, input logic [63:0] res, input int tag, input int rob, input logic [BW-1:0] mask);
    fu_done_i[l]                     = 1'b1;
    fu_result_i[64*l +: 64]          = res;
    fu_dest_tag_i[PW*l +: PW]        = PW'(tag);
    fu_rob_idx_i[(RW+1)*l +: (RW+1)] = (RW+1)'(rob);
    fu_br_mask_i[BW*l +: BW]         = mask;
  endtask

  task automatic idle(input int l);
    fu_done_i[l] = 1'b0;
  endtask

  always @(negedge clk) begin
    if (cdb_valid_o) begin
      exp_t e;
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL cdb_unexpected: got res=0x%0h tag=%0d rob=%0d mask=%b, none expected",
                 cdb_result_o, cdb_tag_o, cdb_rob_idx_o, cdb_br_mask_o);
      end else begin
        e = sb.pop_front();
        if ({cdb_result_o, cdb_tag_o, cdb_rob_idx_o, cdb_br_mask_o} !== e) begin
          errors++;
          $display("FAIL cdb_data: got res=0x%0h tag=%0d rob=%0d mask=%b expected res=0x%0h tag=%0d rob=%0d mask=%b",
                   cdb_result_o, cdb_tag_o, cdb_rob_idx_o, cdb_br_mask_o, e.res, e.tag, e.rob, e.mask);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  logic [1:0]  bp_st [4] = '{2'b00, 2'b00, 2'b01, 2'b10};
  logic [63:0] bp_r0 [4] = '{64'h100, 64'h101, 64'h102, 64'h102};
  int          bp_o0 [4] = '{0, 1, 2, 2};
  logic [63:0] bp_r1 [4] = '{64'h200, 64'h201, 64'h202, 64'h203};

  initial begin
    #1 rst = 1'b0;
    #1;
    chk("reset_valid", 64'(cdb_valid_o), 64'd0);
    chk("reset_stall", 64'(fu_stall_o), 64'd0);
    chk("reset_result", cdb_result_o, 64'd0);
    chk("reset_tag_rob_mask", 64'({cdb_tag_o, cdb_rob_idx_o, cdb_br_mask_o}), 64'd0);
    repeat (2) @(negedge clk);
    rst = 1'b1;

    // Round-robin bursts from pointer 0
    for (int l = 0; l < N; l++) begin
      drive(l, 64'hA0 + 64'(l), l, l, 4'b0000);
      expect_cdb(64'hA0 + 64'(l), l, l, 4'b0000);
    end
    @(negedge clk);
    for (int l = 0; l < N; l++) idle(l);
    repeat (5) @(negedge clk);
    chk("rr_idle_after_burst", 64'(cdb_valid_o), 64'd0);
    for (int l = 0; l < N; l++) begin
      drive(l, 64'hB0 + 64'(l), l + 4, l + 4, 4'b0000);
      expect_cdb(64'hB0 + 64'(l), l + 4, l + 4, 4'b0000);
    end
    @(negedge clk);
    for (int l = 0; l < N; l++) idle(l);
    repeat (5) @(negedge clk);

    // Single result latency and pulse width
    drive(0, 64'h1234, 5, 3, 4'b0000);
    expect_cdb(64'h1234, 5, 3, 4'b0000);
    @(negedge clk);
    idle(0);
    chk("single_not_yet", 64'(cdb_valid_o), 64'd0);
    chk("single_stall", 64'(fu_stall_o), 64'd0);
    @(negedge clk);
    chk("single_valid", 64'(cdb_valid_o), 64'd1);
    @(negedge clk);
    chk("single_pulse", 64'(cdb_valid_o), 64'd0);
    repeat (2) @(negedge clk);

    // Back-pressure on lanes 0/1, pointer at 1; FU holds a stalled value
    expect_cdb(64'h200, 11, 8, 4'b0000);
    expect_cdb(64'h100, 10, 0, 4'b0000);
    expect_cdb(64'h201, 11, 9, 4'b0000);
    expect_cdb(64'h101, 10, 1, 4'b0000);
    expect_cdb(64'h202, 11, 10, 4'b0000);
    expect_cdb(64'h102, 10, 2, 4'b0000);
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("bp_stall_%0d", k), 64'(fu_stall_o[1:0]), 64'(bp_st[k]));
      drive(0, bp_r0[k], 10, bp_o0[k], 4'b0000);
      drive(1, bp_r1[k], 11, 8 + k, 4'b0000);
      @(negedge clk);
    end
    chk("bp_stall_4", 64'(fu_stall_o[1:0]), 64'd1);
    idle(0);
    idle(1);
    @(negedge clk);
    chk("bp_stall_5", 64'(fu_stall_o[1:0]), 64'd0);
    repeat (4) @(negedge clk);

    // Recovery squash on lane 2 (pointer at 1), with pred_correct also high
    drive(2, 64'hC0, 20, 1, 4'b0010);
    drive(1, 64'hC1, 21, 2, 4'b0000);
    expect_cdb(64'hC1, 21, 2, 4'b0000);
    @(negedge clk);
    idle(1);
    drive(2, 64'hC2, 22, 3, 4'b0100);
    @(negedge clk);
    chk("rec_lane2_full", 64'(fu_stall_o[2]), 64'd1);
    idle(2);
    drive(0, 64'hDEAD, 23, 4, 4'b0000);
    rob_br_recovery_i     = 1'b1;
    rob_br_pred_correct_i = 1'b1;
    rob_br_tag_fix_i      = 4'b0010;
    @(negedge clk);
    idle(0);
    rob_br_recovery_i     = 1'b0;
    rob_br_pred_correct_i = 1'b0;
    rob_br_tag_fix_i      = '0;
    chk("rec_no_grant", 64'(cdb_valid_o), 64'd0);
    chk("rec_lane2_stall", 64'(fu_stall_o[2]), 64'd0);
    expect_cdb(64'hC2, 22, 3, 4'b0100);
    repeat (3) @(negedge clk);

    // Mask clear on stored, captured and broadcast entries (pointer at 3)
    drive(0, 64'hE0, 30, 4, 4'b0110);
    drive(3, 64'hE3, 33, 5, 4'b0110);
    @(negedge clk);
    idle(0);
    idle(3);
    drive(1, 64'hE1, 31, 6, 4'b1100);
    rob_br_pred_correct_i = 1'b1;
    rob_br_tag_fix_i      = 4'b0100;
    expect_cdb(64'hE3, 33, 5, 4'b0010);
    expect_cdb(64'hE0, 30, 4, 4'b0010);
    expect_cdb(64'hE1, 31, 6, 4'b1000);
    @(negedge clk);
    idle(1);
    rob_br_pred_correct_i = 1'b0;
    rob_br_tag_fix_i      = '0;
    repeat (4) @(negedge clk);

    // Reset with three entries buffered (pointer at 2: lane 2 goes first)
    for (int l = 0; l < N; l++) drive(l, 64'hF0 + 64'(l), 40 + l, 20 + l, 4'b0000);
    expect_cdb(64'hF2, 42, 22, 4'b0000);
    @(negedge clk);
    for (int l = 0; l < N; l++) idle(l);
    @(negedge clk);
    #2 rst = 1'b0;
    #1;
    chk("mid_reset_valid", 64'(cdb_valid_o), 64'd0);
    chk("mid_reset_result", cdb_result_o, 64'd0);
    chk("mid_reset_tag_rob_mask", 64'({cdb_tag_o, cdb_rob_idx_o, cdb_br_mask_o}), 64'd0);
    chk("mid_reset_stall", 64'(fu_stall_o), 64'd0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (4) @(negedge clk);
    chk("post_reset_idle", 64'(cdb_valid_o), 64'd0);
    drive(1, 64'h5A5A, 50, 30, 4'b0001);
    expect_cdb(64'h5A5A, 50, 30, 4'b0001);
    @(negedge clk);
    idle(1);
    chk("post_reset_not_yet", 64'(cdb_valid_o), 64'd0);
    @(negedge clk);
    chk("post_reset_valid", 64'(cdb_valid_o), 64'd1);

    for (int i = 0; i < 20 && sb.size() != 0; i++) @(negedge clk);
    chk("scoreboard_drained", 64'(sb.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fu_cdb_arb.md
Name: fu_cdb_arb

Overview:
- Writeback-side consumer of the functional-unit result interface: done, result, dest tag, ROB index, branch mask and stall.
- Accepts completed results from NUM_FU functional units into small per-lane FIFOs and drives the registered common data bus (CDB), one result per cycle, using round-robin arbitration.
- Drives the per-FU stall back-pressure and applies branch-recovery squash and branch-mask clearing to every buffered result.
- Sits between the FU outputs and the CDB consumers: RS wakeup, PRF write and ROB complete.

Parameters:
- NUM_FU, 4: number of FU lanes, 2..8.
- LANE_DEPTH, 2: entries per lane FIFO; only 2 is supported.

Ports:
- clk  in  1  clock
- rst  in  1  reset; asynchronous, active-low
- fu_done_i  in  NUM_FU  per-lane result-valid (FU done)
- fu_result_i  in  64*NUM_FU  per-lane 64-bit result, lane i at [64i+63:64i]
- fu_dest_tag_i  in  PRF_IDX_W*NUM_FU  per-lane destination physical register
- fu_rob_idx_i  in  (ROB_IDX_W+1)*NUM_FU  per-lane ROB index
- fu_br_mask_i  in  BR_MASK_W*NUM_FU  per-lane branch mask
- rob_br_recovery_i  in  1  mispredict recovery this cycle
- rob_br_pred_correct_i  in  1  branch resolved correct this cycle
- rob_br_tag_fix_i  in  BR_MASK_W  one-hot tag of the resolving branch
- fu_stall_o  out  NUM_FU  per-lane back-pressure to the FU
- cdb_valid_o  out  1  broadcast valid
- cdb_result_o  out  64  broadcast result
- cdb_tag_o  out  PRF_IDX_W  broadcast destination tag
- cdb_rob_idx_o  out  ROB_IDX_W+1  broadcast ROB index
- cdb_br_mask_o  out  BR_MASK_W  broadcast branch mask

Behaviour:
- Reset (rst low, asynchronous): all lane entries invalid, counts 0, RR pointer 0, all cdb_* outputs 0, fu_stall_o 0.
- Lane FIFO:
  - Two slots, slot0 is the head. Each slot holds valid, result, tag, rob_idx and br_mask.
  - count_i is the number of valid slots, always compacted toward slot0.
- Stall:
  - fu_stall_o[i] = (count_i == 2).
  - Decoded from registered state only; no combinational path from any input.
  - Stays asserted even if lane i is granted in the same cycle (conservative).
- Push: at a clock edge, lane i captures its inputs when fu_done_i[i] & ~fu_stall_o[i] & ~rob_br_recovery_i.
  - Inputs on a recovery cycle are ignored; the FU holds or clears its own output.
- Arbitration:
  - Candidates are lanes with a valid slot0.
  - Round-robin search starts at the RR pointer; the winner's slot0 is popped and written to the cdb_* registers at the same edge.
  - The RR pointer becomes winner+1 modulo NUM_FU. With no winner, the pointer holds and cdb_valid_o goes to 0.
  - Simultaneous push and pop on one lane: pop slot0, shift slot1 down, and place the new entry at the first free slot.
- Latency:
  - Input sampled at edge E goes to the CDB at edge E+1 at the earliest; no bypass.
  - Sustained one result per cycle per lane when that lane is the only requester.
  - cdb_valid_o is a single-cycle pulse per entry.
- Recovery cycle (rob_br_recovery_i=1):
  - No grant; cdb_valid_o goes to 0 next edge; RR pointer holds.
  - Every lane slot with (br_mask & rob_br_tag_fix_i) != 0 is invalidated.
  - Survivors are compacted (slot1 moves to slot0 if slot0 is killed) and counts are updated, all at the same edge.
- Correct prediction (rob_br_pred_correct_i=1, no recovery):
  - At the edge, rob_br_tag_fix_i bits are cleared from all stored slot masks, from masks captured that cycle, and from the mask written to cdb_br_mask_o.
- rob_br_recovery_i and rob_br_pred_correct_i both high: recovery takes precedence.
- Lanes keep their own order; no ordering is guaranteed across lanes.

Test Plan:
- Single result: lane 0 done=1 for one cycle, result=0x1234, tag=5, rob=3, mask=0 → cdb_valid_o=1 for exactly one cycle, one edge after capture, carrying 0x1234/5/3; fu_stall_o stays 0.
- Round-robin order: all 4 lanes done=1 in the same cycle with results 0xA0..0xA3, pointer at 0 → broadcasts on 4 consecutive cycles in order A0, A1, A2, A3; next simultaneous burst starts at lane 0 again.
- Back-pressure: lanes 0 and 1 done held high for 4 cycles, distinct results each cycle → lane stall asserts once count reaches 2; no result lost or duplicated; per-lane order preserved.
- Recovery squash: lane 2 holds slot0 mask=0b0010 and slot1 mask=0b0100, recovery with tag_fix=0b0010 → slot0 killed, slot1 becomes head; cdb_valid_o=0 that next cycle; the surviving entry broadcasts afterwards.
- Mask clear: buffered entry mask=0b0110, pred_correct with tag_fix=0b0100 → broadcast shows cdb_br_mask_o=0b0010.
- Reset mid-operation: rst low while 3 entries are buffered → all outputs 0 immediately; after release there are no stale broadcasts and the first new input appears one edge after capture.
